// File: rtl/cpu_multicycle.sv
// cpu_multicycle
// Small multi-cycle MIPS-subset core. It has one unified memory port for
// instructions and data. Each instruction walks through
// FETCH -> DECODE -> EXECUTE -> (MEMORY) -> (WRITEBACK).
// A memory transfer completes on a rising edge where mem_req and mem_ready
// are both high. Any wait cycle simply keeps the core in its current state.
//
// Ports
//   clock      : single clock, all state changes on the rising edge
//   reset      : synchronous, active-high
//   mem_req    : memory request (instruction fetch or lw/sw data access)
//   mem_we     : 1 = write, 0 = read
//   mem_addr   : byte address of the request
//   mem_wdata  : store data
//   mem_rdata  : read data, taken when the transfer completes
//   mem_ready  : completes the pending transfer
//   pc_out     : architectural PC
//   retire     : one-cycle pulse in the last cycle of every instruction
//   halted     : core is stopped in HALT until the next reset
module cpu_multicycle #(
   parameter logic [31:0] RESET_PC         = 32'h0000_0000,
   parameter int          ADDR_WIDTH       = 32,
   parameter bit          HALT_ON_MISALIGN = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata,
   input  logic                  mem_ready,
   output logic [ADDR_WIDTH-1:0] pc_out,
   output logic                  retire,
   output logic                  halted
);

   typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT} state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   state_t                state, next_state;
   logic [ADDR_WIDTH-1:0] pc, target;
   logic [31:0]           ir, a, b, alu_out, mdr;
   logic [31:0]           regs [32];

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, wb_reg;
   logic [31:0] imm_sext, pc_ext, branch_full, jump_full, addr_full;
   logic [31:0] alu_result, rs_val, rt_val, wb_data;
   logic        opcode_ok, misaligned;

   assign op        = ir[31:26];
   assign rs        = ir[25:21];
   assign rt        = ir[20:16];
   assign rd        = ir[15:11];
   assign funct     = ir[5:0];
   assign imm_sext  = {{16{ir[15]}}, ir[15:0]};
   assign pc_ext    = 32'(pc);

   // pc already holds PC+4 once DECODE is reached. Branch and jump targets
   // are relative to that value. Both targets are truncated to ADDR_WIDTH
   // when they are loaded, so PC arithmetic wraps naturally.
   assign branch_full = pc_ext + (imm_sext << 2);
   assign jump_full   = {pc_ext[31:28], ir[25:0], 2'b00};
   assign addr_full   = a + imm_sext;
   assign misaligned  = (addr_full[1:0] != 2'b00);

   assign wb_reg    = (op == OP_RTYPE) ? rd : rt;
   assign wb_data   = (op == OP_LW) ? mdr : alu_out;
   assign mem_wdata = b;
   assign pc_out    = pc;

   // Register file read ports. r0 is forced to zero on read, so a stray
   // write path can never leak a value out of it.
   always_comb begin
      rs_val = (rs == 5'd0) ? 32'd0 : regs[rs];
      rt_val = (rt == 5'd0) ? 32'd0 : regs[rt];
   end

   // Checks whether the instruction in IR is one the core implements.
   // R-type instructions are accepted only for the five supported funct codes.
   always_comb begin
      opcode_ok = 1'b0;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: opcode_ok = 1'b1;
               default:                               opcode_ok = 1'b0;
            endcase
         end
         OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL: opcode_ok = 1'b1;
         default:                                    opcode_ok = 1'b0;
      endcase
   end

   // ALU. add, sub and addi wrap silently. slt compares the operands as
   // signed values.
   always_comb begin
      alu_result = a + imm_sext;
      if (op == OP_RTYPE) begin
         case (funct)
            FN_SUB:  alu_result = a - b;
            FN_AND:  alu_result = a & b;
            FN_OR:   alu_result = a | b;
            FN_SLT:  alu_result = {31'd0, ($signed(a) < $signed(b))};
            default: alu_result = a + b;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic and memory/status outputs. The request outputs are
   // driven only from registered values (pc, alu_out, b, ir), so they stay
   // stable for as long as mem_ready is held low. Reset masks every
   // strobe, so nothing is requested or retired during the reset cycle.
   always_comb begin
      next_state = state;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = pc;
      retire     = 1'b0;
      halted     = 1'b0;
      case (state)
         FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) next_state = DECODE;
         end
         DECODE: begin
            next_state = opcode_ok ? EXECUTE : HALT;
         end
         EXECUTE: begin
            case (op)
               OP_RTYPE, OP_ADDI: next_state = WRITEBACK;
               OP_LW, OP_SW: begin
                  if (misaligned && HALT_ON_MISALIGN) next_state = HALT;
                  else                                next_state = MEMORY;
               end
               OP_BEQ, OP_J, OP_JAL: begin
                  retire     = 1'b1;
                  next_state = FETCH;
               end
               default: next_state = HALT;
            endcase
         end
         MEMORY: begin
            mem_req  = 1'b1;
            mem_we   = (op == OP_SW);
            mem_addr = alu_out[ADDR_WIDTH-1:0];
            if (mem_ready) begin
               retire     = (op == OP_SW);
               next_state = (op == OP_SW) ? FETCH : WRITEBACK;
            end
         end
         WRITEBACK: begin
            retire     = 1'b1;
            next_state = FETCH;
         end
         HALT: begin
            halted = 1'b1;
         end
         default: next_state = FETCH;
      endcase
      if (reset) begin
         mem_req    = 1'b0;
         retire     = 1'b0;
         halted     = 1'b0;
         next_state = FETCH;
      end
   end

   // Datapath registers and the register file.
   // Each state updates only the registers it owns. With HALT_ON_MISALIGN=0,
   // the low two address bits are dropped when the effective address is
   // latched. When misaligned accesses halt instead, that latched address is
   // never used.
   always_ff @(posedge clock) begin
      if (reset) begin
         pc      <= RESET_PC[ADDR_WIDTH-1:0];
         target  <= '0;
         ir      <= '0;
         a       <= '0;
         b       <= '0;
         alu_out <= '0;
         mdr     <= '0;
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else begin
         case (state)
            FETCH: begin
               if (mem_ready) begin
                  ir <= mem_rdata;
                  pc <= pc + ADDR_WIDTH'(32'd4);
               end
            end
            DECODE: begin
               a      <= rs_val;
               b      <= rt_val;
               target <= branch_full[ADDR_WIDTH-1:0];
            end
            EXECUTE: begin
               case (op)
                  OP_RTYPE, OP_ADDI: alu_out <= alu_result;
                  OP_LW, OP_SW:      alu_out <= {addr_full[31:2], 2'b00};
                  OP_BEQ:            if (a == b) pc <= target;
                  OP_J:              pc <= jump_full[ADDR_WIDTH-1:0];
                  OP_JAL: begin
                     pc       <= jump_full[ADDR_WIDTH-1:0];
                     regs[31] <= pc_ext;
                  end
                  default: ;
               endcase
            end
            MEMORY: begin
               if (mem_ready && op == OP_LW) mdr <= mem_rdata;
            end
            WRITEBACK: begin
               if (wb_reg != 5'd0) regs[wb_reg] <= wb_data;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Testbench for cpu_multicycle: behavioural memory with programmable wait
// states, a retire/transfer monitor, table-driven ALU vectors and directed
// sequences for timing, branches, jumps, halting and reset.
module tb_cpu_multicycle;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        mem_req, mem_we, retire, halted;
   logic [31:0] mem_addr, mem_wdata, pc_out;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;

   cpu_multicycle dut (
      .clock(clock), .reset(reset),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .pc_out(pc_out), .retire(retire), .halted(halted)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   logic [31:0] mem [256];
   int          wait_cycles = 0;
   int          wait_cnt    = 0;
   logic [31:0] xfer_q [$];
   logic [63:0] store_q [$];
   int          retire_q [$];
   int          cyc = 0;
   int          halt_cyc = 0;
   int          stab_errs = 0;
   bit          prev_waiting = 0;
   logic [31:0] p_addr, p_wdata;
   logic        p_we;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expected;
      int          cycles;
   } vec_t;

   vec_t vecs [10];

   // Memory model: answers a request after wait_cycles cycles of mem_ready=0
   // and logs every completed transfer and store.
   initial begin
      forever begin
         @(negedge clock);
         if (reset) begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
            xfer_q.delete();
            store_q.delete();
         end else if (mem_req) begin
            if (wait_cnt >= wait_cycles) begin
               mem_ready = 1'b1;
               mem_rdata = mem[mem_addr[9:2]];
               xfer_q.push_back(mem_addr);
               if (mem_we) begin
                  mem[mem_addr[9:2]] = mem_wdata;
                  store_q.push_back({mem_addr, mem_wdata});
               end
               wait_cnt = 0;
            end else begin
               mem_ready = 1'b0;
               wait_cnt++;
            end
         end else begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
         end
      end
   end

   // Monitor: cycle numbers since reset release (cycle 1 is the first),
   // retire times, first halted cycle and request stability while waiting.
   initial begin
      forever begin
         @(negedge clock);
         #1;
         if (reset) begin
            cyc = 0;
            halt_cyc = 0;
            stab_errs = 0;
            prev_waiting = 0;
            retire_q.delete();
         end else begin
            cyc++;
            if (retire) retire_q.push_back(cyc);
            if (halted && halt_cyc == 0) halt_cyc = cyc;
            if (prev_waiting && (!mem_req || mem_addr != p_addr || mem_we != p_we ||
                                 (mem_we && mem_wdata != p_wdata)))
               stab_errs++;
            prev_waiting = mem_req && !mem_ready;
            p_addr  = mem_addr;
            p_we    = mem_we;
            p_wdata = mem_wdata;
         end
      end
   end

   function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] jtype(logic [5:0] op, logic [25:0] tgt);
      return {op, tgt};
   endfunction

   function automatic int rget(int i);
      return (i < retire_q.size()) ? retire_q[i] : -1;
   endfunction

   function automatic logic [31:0] xget(int i);
      return (i < xfer_q.size()) ? xfer_q[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [63:0] sget(int i);
      return (i < store_q.size()) ? store_q[i] : 64'hDEAD_BEEF_DEAD_BEEF;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic hold_reset();
      reset = 1'b1;
      @(posedge clock);
      #1;
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
   endtask

   task automatic applyStimulus(input int waits);
      wait_cycles = waits;
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   // which: 0 = retire count, 1 = store count
   task automatic wait_for(input int which, input int target, input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         if ((which == 0 ? retire_q.size() : store_q.size()) >= target) return;
         @(posedge clock);
         #1;
      end
      tests++;
      fails++;
      $display("[TB] FAIL %s: timeout after %0d cycles, count %0d, required %0d", name, budget,
               (which == 0 ? retire_q.size() : store_q.size()), target);
   endtask

   logic [31:0] halt_instr [3];
   int          halt_exp [3];

   initial begin
      logic [31:0] spin;
      spin = itype(6'h04, 5'd0, 5'd0, 16'hFFFF);

      vecs[0] = '{"add",      rtype(1, 2, 3, 6'h20), 32'd5,         32'd7,         32'd12,        4};
      vecs[1] = '{"add_wrap", rtype(1, 2, 3, 6'h20), 32'hFFFF_FFFF, 32'd1,         32'd0,         4};
      vecs[2] = '{"sub_neg",  rtype(1, 2, 3, 6'h22), 32'd3,         32'd5,         32'hFFFF_FFFE, 4};
      vecs[3] = '{"and",      rtype(1, 2, 3, 6'h24), 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 4};
      vecs[4] = '{"or",       rtype(1, 2, 3, 6'h25), 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 4};
      vecs[5] = '{"slt_t",    rtype(1, 2, 3, 6'h2A), 32'hFFFF_FFFF, 32'd1,         32'd1,         4};
      vecs[6] = '{"slt_f",    rtype(1, 2, 3, 6'h2A), 32'd1,         32'hFFFF_FFFF, 32'd0,         4};
      vecs[7] = '{"slt_edge", rtype(1, 2, 3, 6'h2A), 32'h7FFF_FFFF, 32'h8000_0000, 32'd0,         4};
      vecs[8] = '{"addi_neg", itype(6'h08, 1, 3, 16'hFFFE), 32'd1,  32'd0,         32'hFFFF_FFFF, 4};
      vecs[9] = '{"addi_ovf", itype(6'h08, 1, 3, 16'h0001), 32'h7FFF_FFFF, 32'd0,  32'h8000_0000, 4};

      // Reset state, then addi/addi/add with retire timing
      hold_reset();
      mem[0] = itype(6'h08, 0, 1, 16'd5);
      mem[1] = itype(6'h08, 0, 2, 16'd7);
      mem[2] = rtype(1, 2, 3, 6'h20);
      mem[3] = itype(6'h2B, 0, 3, 16'h0040);
      mem[4] = spin;
      @(negedge clock); #1;
      checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
      checkOutput("rst_retire",  {31'd0, retire},  32'd0);
      checkOutput("rst_halted",  {31'd0, halted},  32'd0);
      applyStimulus(0);
      @(negedge clock); #1;
      checkOutput("first_fetch_req",  {31'd0, mem_req}, 32'd1);
      checkOutput("first_fetch_we",   {31'd0, mem_we},  32'd0);
      checkOutput("first_fetch_addr", mem_addr,         32'h0);
      checkOutput("first_pc",         pc_out,           32'h0);
      wait_for(1, 1, 60, "seqA_store");
      checkOutput("seqA_retire0", rget(0), 32'd4);
      checkOutput("seqA_retire1", rget(1), 32'd8);
      checkOutput("seqA_retire2", rget(2), 32'd12);
      checkOutput("seqA_r3", sget(0)[31:0], 32'd12);
      checkOutput("seqA_addr", sget(0)[63:32], 32'h40);

      // ALU vectors: load operands with lw, run the op, store r3
      for (int v = 0; v < 10; v++) begin
         hold_reset();
         mem[0]  = itype(6'h23, 0, 1, 16'h0080);
         mem[1]  = itype(6'h23, 0, 2, 16'h0084);
         mem[2]  = vecs[v].instr;
         mem[3]  = itype(6'h2B, 0, 3, 16'h0088);
         mem[4]  = spin;
         mem[32] = vecs[v].a;
         mem[33] = vecs[v].b;
         applyStimulus(0);
         wait_for(1, 1, 80, {vecs[v].name, "_timeout"});
         checkOutput({vecs[v].name, "_result"}, sget(0)[31:0], vecs[v].expected);
         checkOutput({vecs[v].name, "_addr"},   sget(0)[63:32], 32'h88);
         checkOutput({vecs[v].name, "_cycles"}, rget(2) - rget(1), vecs[v].cycles);
      end

      // Wait states: sw then lw with 3 wait cycles per request
      hold_reset();
      mem[0] = itype(6'h08, 0, 1, 16'd5);
      mem[1] = itype(6'h08, 0, 2, 16'd7);
      mem[2] = rtype(1, 2, 3, 6'h20);
      mem[3] = itype(6'h2B, 0, 3, 16'h0040);
      mem[4] = itype(6'h23, 0, 4, 16'h0040);
      mem[5] = itype(6'h2B, 0, 4, 16'h0044);
      mem[6] = spin;
      applyStimulus(3);
      wait_for(1, 2, 200, "wait_timeout");
      checkOutput("wait_add_cycles", rget(2) - rget(1), 32'd7);
      checkOutput("wait_sw_cycles",  rget(3) - rget(2), 32'd10);
      checkOutput("wait_lw_cycles",  rget(4) - rget(3), 32'd11);
      checkOutput("wait_r4",         sget(1)[31:0], 32'd12);
      checkOutput("wait_r4_addr",    sget(1)[63:32], 32'h44);
      checkOutput("wait_stable",     stab_errs, 32'd0);

      // beq loop at 0x10 reached by j
      hold_reset();
      mem[0] = itype(6'h08, 0, 1, 16'd3);
      mem[1] = jtype(6'h02, 26'h4);
      mem[4] = itype(6'h04, 1, 1, 16'hFFFF);
      applyStimulus(0);
      wait_for(0, 5, 60, "beq_timeout");
      checkOutput("j_cycles",    rget(1) - rget(0), 32'd3);
      checkOutput("beq_cycles0", rget(2) - rget(1), 32'd3);
      checkOutput("beq_cycles1", rget(3) - rget(2), 32'd3);
      checkOutput("beq_fetch0",  xget(2), 32'h10);
      checkOutput("beq_fetch1",  xget(3), 32'h10);
      checkOutput("beq_fetch2",  xget(4), 32'h10);

      // jal at 0x20 with target field 0x40 -> 0x100, r31 = 0x24
      hold_reset();
      mem[0]  = jtype(6'h02, 26'h8);
      mem[8]  = jtype(6'h03, 26'h40);
      mem[64] = itype(6'h2B, 0, 31, 16'h0080);
      mem[65] = spin;
      applyStimulus(0);
      wait_for(1, 1, 60, "jal_timeout");
      checkOutput("jal_cycles", rget(1) - rget(0), 32'd3);
      checkOutput("jal_fetch",  xget(2), 32'h100);
      checkOutput("jal_r31",    sget(0)[31:0], 32'h24);

      // Halting cases: bad opcode, bad funct, misaligned lw at 0x41
      halt_instr[0] = 32'hFC00_0000;              halt_exp[0] = 7;
      halt_instr[1] = rtype(1, 1, 3, 6'h21);      halt_exp[1] = 7;
      halt_instr[2] = itype(6'h23, 1, 2, 16'h0);  halt_exp[2] = 8;
      for (int h = 0; h < 3; h++) begin
         hold_reset();
         mem[0] = itype(6'h08, 0, 1, 16'h0041);
         mem[1] = halt_instr[h];
         applyStimulus(0);
         repeat (20) @(posedge clock);
         #1;
         checkOutput($sformatf("halt%0d_cycle", h),   halt_cyc, halt_exp[h]);
         checkOutput($sformatf("halt%0d_flag", h),    {31'd0, halted}, 32'd1);
         checkOutput($sformatf("halt%0d_req", h),     {31'd0, mem_req}, 32'd0);
         checkOutput($sformatf("halt%0d_xfers", h),   xfer_q.size(), 32'd2);
         checkOutput($sformatf("halt%0d_retires", h), retire_q.size(), 32'd1);
      end

      // Reset while a fetch is waiting, then r0 stays zero
      hold_reset();
      mem[0] = itype(6'h08, 0, 0, 16'd9);
      mem[1] = itype(6'h2B, 0, 0, 16'h0080);
      mem[2] = spin;
      applyStimulus(3);
      wait_for(0, 1, 40, "midrst_timeout");
      @(posedge clock); #1;
      checkOutput("midrst_pending", {31'd0, mem_req}, 32'd1);
      reset = 1'b1;
      @(negedge clock); #1;
      checkOutput("midrst_req",    {31'd0, mem_req}, 32'd0);
      checkOutput("midrst_retire", {31'd0, retire},  32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      wait_for(1, 1, 100, "midrst_store_timeout");
      checkOutput("midrst_fetch", xget(0), 32'h0);
      checkOutput("r0_zero",      sget(0)[31:0], 32'd0);
      checkOutput("r0_addr",      sget(0)[63:32], 32'h80);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cpu_multicycle.md
CPU_MULTICYCLE -- requirements
Module: cpu_multicycle

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter ADDR_WIDTH, default 32, legal 8..32: width of PC and memory address.
REQ-003 Parameter HALT_ON_MISALIGN, default 1: 1 = misaligned lw/sw halts; 0 = low 2 address bits forced to 0.
REQ-004 Port clock  input  1: single clock; all state updates on rising edge.
REQ-005 Port reset  input  1: synchronous, active-high reset.
REQ-006 Port mem_req  output  1: unified instruction/data memory request.
REQ-007 Port mem_we  output  1: 1 = write, 0 = read; valid while mem_req=1.
REQ-008 Port mem_addr  output  ADDR_WIDTH: byte address; valid while mem_req=1.
REQ-009 Port mem_wdata  output  32: store data; valid while mem_req=1 and mem_we=1.
REQ-010 Port mem_rdata  input  32: read data; sampled only in a cycle with mem_req=1 and mem_ready=1.
REQ-011 Port mem_ready  input  1: transfer completes on an edge where mem_req=1 and mem_ready=1; ignored otherwise.
REQ-012 Port pc_out  output  ADDR_WIDTH: current architectural PC.
REQ-013 Port retire  output  1: one-cycle pulse in the final cycle of each completed instruction.
REQ-014 Port halted  output  1: core is in HALT.

Function
REQ-015 States SHALL be FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT.
REQ-016 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on completion latch IR, PC<=PC+4, go to DECODE; otherwise hold.
REQ-017 mem_req, mem_we, mem_addr, mem_wdata SHALL stay stable from assertion until completion; mem_req=0 in DECODE, EXECUTE, WRITEBACK, HALT.
REQ-018 DECODE: read rs/rt into A/B; compute branch target PC+(sext(imm)<<2); opcode not in REQ-019 goes to HALT, else EXECUTE.
REQ-019 Supported: R-type (op 0) funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt; op 0x08 addi, 0x23 lw, 0x2B sw, 0x04 beq, 0x02 j, 0x03 jal; R-type with other funct goes to HALT from DECODE.
REQ-020 add/sub/addi SHALL wrap modulo 2^32 with no overflow trap; slt signed, result 1 or 0.
REQ-021 EXECUTE R-type/addi: compute ALU result, go to WRITEBACK.
REQ-022 EXECUTE lw/sw: address A+sext(imm), truncated to ADDR_WIDTH; misaligned with HALT_ON_MISALIGN=1 goes to HALT; else MEMORY.
REQ-023 EXECUTE beq: if A==B, PC<=branch target; retire=1; go to FETCH.
REQ-024 EXECUTE j/jal: PC<= low ADDR_WIDTH bits of {PC[31:28] (zero-extended PC), target, 2'b00}; jal also writes old PC (already +4) to r31; retire=1; go to FETCH.
REQ-025 MEMORY: lw reads, latches mem_rdata on completion, goes to WRITEBACK; sw writes B, retire=1 on completion cycle, goes to FETCH.
REQ-026 WRITEBACK: write rd (R-type) or rt (addi, lw); retire=1; go to FETCH.
REQ-027 Register file 32x32, two combinational reads, one write; writes to r0 discarded; r0 reads 0.
REQ-028 Zero-wait-state cycle counts SHALL be: R-type/addi 4, lw 5, sw 4, beq/j/jal 3; each wait cycle adds 1.
REQ-029 HALT: halted=1, no memory request, no state change; exit only by reset.
REQ-030 PC arithmetic SHALL wrap modulo 2^ADDR_WIDTH.

Reset
REQ-031 Reset SHALL set state=FETCH, PC=RESET_PC, all registers 0, IR 0, retire=0, halted=0; mem_req=0 during the reset cycle.
REQ-032 Reset mid-transaction SHALL abandon the request; the first cycle after reset deassertion is a FETCH at RESET_PC.
REQ-033 Reset has priority over every other event in the same cycle.

Verification
REQ-034 Zero-wait memory, program addi r1,r0,5; addi r2,r0,7; add r3,r1,r2 -> r3=12; retire pulses at cycles 4, 8, 12 after reset release.
REQ-035 sw r3,0x40(r0) then lw r4,0x40(r0) with mem_ready held low 3 cycles per request -> mem_req/addr/we stable throughout; r4=12; lw takes 5+3+3 cycles.
REQ-036 beq r1,r1,-1 at 0x10 -> PC returns to 0x10 after 3 cycles; repeats indefinitely; jal at 0x20 with target 0x40 -> PC=0x100, r31=0x24.
REQ-037 Opcode 0x3F, or lw at address 0x41 with HALT_ON_MISALIGN=1 -> halted=1 within 1 cycle of DECODE/EXECUTE, mem_req stays 0, no register changes.
REQ-038 Reset asserted while FETCH awaits mem_ready -> next cycle mem_req=0; after release, fetch at RESET_PC; addi r0,r0,9 -> r0 reads 0.
